// File: rtl/montgomery_exp_pkg.sv
// rtl/montgomery_exp_pkg.sv - shared constants for the modular exponentiation controller
package montgomery_exp_pkg;

  localparam int DEF_WIDTH     = 1024;
  localparam int DEF_EXP_WIDTH = 1024;

  // Plain integer one: multiplying by it leaves the Montgomery domain.
  localparam logic [DEF_WIDTH-1:0] ONE = DEF_WIDTH'(1);

  localparam logic [3:0] S_IDLE      = 4'd0;
  localparam logic [3:0] S_LOAD      = 4'd1;
  localparam logic [3:0] S_SCAN      = 4'd2;
  localparam logic [3:0] S_TO_MONT   = 4'd3;
  localparam logic [3:0] S_W_TO      = 4'd4;
  localparam logic [3:0] S_SQUARE    = 4'd5;
  localparam logic [3:0] S_W_SQ      = 4'd6;
  localparam logic [3:0] S_MULT      = 4'd7;
  localparam logic [3:0] S_W_MUL     = 4'd8;
  localparam logic [3:0] S_NEXT      = 4'd9;
  localparam logic [3:0] S_FROM_MONT = 4'd10;
  localparam logic [3:0] S_W_FROM    = 4'd11;
  localparam logic [3:0] S_DONE      = 4'd12;

endpackage

// File: rtl/montgomery_exp_scanner.sv
// rtl/montgomery_exp_scanner.sv - exponent shift register and remaining-bit counter
module montgomery_exp_scanner #(
  parameter int EXP_WIDTH = 1024
) (
  input  logic                 clk,
  input  logic                 resetn,
  input  logic                 load,
  input  logic                 shift,
  input  logic [EXP_WIDTH-1:0] in_e,
  output logic                 msb,
  output logic                 cnt_zero,
  output logic                 cnt_last
);

  localparam int CW = $clog2(EXP_WIDTH + 1);

  logic [EXP_WIDTH-1:0] e_sh;
  logic [CW-1:0]        cnt;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      e_sh <= '0;
      cnt  <= '0;
    end else if (load) begin
      e_sh <= in_e;
      cnt  <= CW'(EXP_WIDTH);
    end else if (shift && !cnt_zero) begin
      e_sh <= e_sh << 1;
      cnt  <= cnt - 1'b1;
    end
  end

  assign msb      = e_sh[EXP_WIDTH-1];
  assign cnt_zero = (cnt == '0);
  // Lets NEXT decide its successor from the count it is about to leave behind.
  assign cnt_last = (cnt == CW'(1));

endmodule

// File: rtl/montgomery_exp.sv
// rtl/montgomery_exp.sv - left-to-right square-and-multiply x^e mod m over a Montgomery multiplier
module montgomery_exp
  import montgomery_exp_pkg::*;
#(
  parameter int WIDTH     = DEF_WIDTH,
  parameter int EXP_WIDTH = DEF_EXP_WIDTH
) (
  input  logic                 clk,
  input  logic                 resetn,
  input  logic                 start,
  input  logic [WIDTH-1:0]     in_x,
  input  logic [EXP_WIDTH-1:0] in_e,
  input  logic [WIDTH-1:0]     in_m,
  input  logic [WIDTH-1:0]     in_rmodm,
  input  logic [WIDTH-1:0]     in_r2modm,
  output logic                 mm_start,
  output logic [WIDTH-1:0]     mm_a,
  output logic [WIDTH-1:0]     mm_b,
  output logic [WIDTH-1:0]     mm_m,
  input  logic [WIDTH-1:0]     mm_result,
  input  logic                 mm_done,
  output logic                 busy,
  output logic [WIDTH-1:0]     result,
  output logic                 done
);

  localparam logic [WIDTH-1:0] ONE_W = WIDTH'(ONE);

  logic [3:0]       state;
  logic [WIDTH-1:0] x_q, rmodm_q, r2_q, xt, acc;
  logic             sc_msb, sc_cnt_zero, sc_cnt_last, sc_shift;

  // Leading zeros are skipped in SCAN; every processed bit shifts once in NEXT.
  assign sc_shift = ((state == S_SCAN) && !sc_msb) || (state == S_NEXT);

  montgomery_exp_scanner #(.EXP_WIDTH(EXP_WIDTH)) u_scanner (
    .clk      (clk),
    .resetn   (resetn),
    .load     (state == S_LOAD),
    .shift    (sc_shift),
    .in_e     (in_e),
    .msb      (sc_msb),
    .cnt_zero (sc_cnt_zero),
    .cnt_last (sc_cnt_last)
  );

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state    <= S_IDLE;
      x_q      <= '0;
      mm_m     <= '0;
      rmodm_q  <= '0;
      r2_q     <= '0;
      xt       <= '0;
      acc      <= '0;
      mm_start <= 1'b0;
      mm_a     <= '0;
      mm_b     <= '0;
      busy     <= 1'b0;
      result   <= '0;
      done     <= 1'b0;
    end else begin
      mm_start <= 1'b0;
      done     <= 1'b0;
      case (state)
        S_IDLE: if (start) begin
          busy  <= 1'b1;
          state <= S_LOAD;
        end
        S_LOAD: begin
          x_q     <= in_x;
          mm_m    <= in_m;
          rmodm_q <= in_rmodm;
          r2_q    <= in_r2modm;
          state   <= S_SCAN;
        end
        S_SCAN: if (sc_msb || sc_cnt_zero) state <= S_TO_MONT;
        S_TO_MONT: begin
          mm_start <= 1'b1;
          mm_a     <= x_q;
          mm_b     <= r2_q;
          state    <= S_W_TO;
        end
        S_W_TO: if (mm_done) begin
          xt    <= mm_result;
          acc   <= rmodm_q;
          state <= sc_cnt_zero ? S_FROM_MONT : S_SQUARE;
        end
        S_SQUARE: begin
          mm_start <= 1'b1;
          mm_a     <= acc;
          mm_b     <= acc;
          state    <= S_W_SQ;
        end
        S_W_SQ: if (mm_done) begin
          acc   <= mm_result;
          state <= sc_msb ? S_MULT : S_NEXT;
        end
        S_MULT: begin
          mm_start <= 1'b1;
          mm_a     <= acc;
          mm_b     <= xt;
          state    <= S_W_MUL;
        end
        S_W_MUL: if (mm_done) begin
          acc   <= mm_result;
          state <= S_NEXT;
        end
        S_NEXT: state <= sc_cnt_last ? S_FROM_MONT : S_SQUARE;
        S_FROM_MONT: begin
          mm_start <= 1'b1;
          mm_a     <= acc;
          mm_b     <= ONE_W;
          state    <= S_W_FROM;
        end
        S_W_FROM: if (mm_done) begin
          result <= mm_result;
          done   <= 1'b1;
          busy   <= 1'b0;
          state  <= S_DONE;
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_montgomery_exp.sv
// tb/tb_montgomery_exp.sv - directed vector bench with a behavioural variable-latency Montgomery multiplier
module tb_montgomery_exp;

  localparam int W = 16;

  logic         clk = 1'b0;
  logic         resetn = 1'b0;
  logic         start = 1'b0;
  logic [W-1:0] in_x = '0, in_e = '0, in_m = '0, in_rmodm = '0, in_r2modm = '0;
  logic         mm_start;
  logic [W-1:0] mm_a, mm_b, mm_m;
  logic [W-1:0] mm_result = '0;
  logic         mm_done = 1'b0;
  logic         busy;
  logic [W-1:0] result;
  logic         done;

  int n_checks = 0;
  int n_errors = 0;
  int n_mm = 0;
  int n_done = 0;
  int n_rst = 0;

  typedef struct {
    logic [W-1:0] x, e, m, res;
    int           mm;
  } vec_t;
  vec_t vt[10];

  montgomery_exp #(.WIDTH(W), .EXP_WIDTH(W)) dut (
    .clk       (clk),
    .resetn    (resetn),
    .start     (start),
    .in_x      (in_x),
    .in_e      (in_e),
    .in_m      (in_m),
    .in_rmodm  (in_rmodm),
    .in_r2modm (in_r2modm),
    .mm_start  (mm_start),
    .mm_a      (mm_a),
    .mm_b      (mm_b),
    .mm_m      (mm_m),
    .mm_result (mm_result),
    .mm_done   (mm_done),
    .busy      (busy),
    .result    (result),
    .done      (done)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (mm_start) n_mm <= n_mm + 1;
    if (done) n_done <= n_done + 1;
  end

  always @(posedge clk) if (!resetn) n_rst <= n_rst + 1;

  function automatic logic [W-1:0] mont(input logic [W-1:0] a, b, m);
    longint t = 0;
    for (int i = 0; i < W; i++) begin
      if (a[i]) t += longint'(b);
      if (t[0]) t += longint'(m);
      t = t >> 1;
    end
    if (t >= longint'(m)) t -= longint'(m);
    return W'(t);
  endfunction

  function automatic longint gpow(input longint x, input longint e, input longint m);
    longint r = 1;
    for (int i = W - 1; i >= 0; i--) begin
      r = (r * r) % m;
      if (e[i]) r = (r * x) % m;
    end
    return r;
  endfunction

  // Multiplier model: shares resetn, so a reset abandons the pending operation.
  initial begin : mm_model
    logic [W-1:0] a, b, m;
    int lat, rst0;
    forever begin
      @(negedge clk);
      mm_done = 1'b0;
      mm_result = '0;
      if (mm_start) begin
        a = mm_a; b = mm_b; m = mm_m;
        rst0 = n_rst;
        lat = $urandom_range(3, 40);
        for (int k = 1; k < lat; k++) @(negedge clk);
        if (n_rst == rst0) begin
          mm_result = mont(a, b, m);
          mm_done = 1'b1;
        end
      end
    end
  end

  task automatic chk(input string name, input longint got, input longint exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d", name, got, exp);
    end
  endtask

  task automatic check_zero(input string name);
    chk({name, "_busy"}, busy, 0);
    chk({name, "_done"}, done, 0);
    chk({name, "_mm_start"}, mm_start, 0);
    chk({name, "_mm_a"}, mm_a, 0);
    chk({name, "_mm_b"}, mm_b, 0);
    chk({name, "_mm_m"}, mm_m, 0);
    chk({name, "_result"}, result, 0);
  endtask

  task automatic setup(input logic [W-1:0] x, e, m);
    in_x = x;
    in_e = e;
    in_m = m;
    in_rmodm  = W'((64'd1 << W) % 64'(m));
    in_r2modm = W'((64'd1 << (2 * W)) % 64'(m));
  endtask

  task automatic run(input logic [W-1:0] x, e, m, exp_res, input int exp_mm,
                     input bit poke, input string name);
    int base_mm, base_done;
    bit ok;
    @(negedge clk);
    setup(x, e, m);
    base_mm = n_mm;
    base_done = n_done;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    ok = 1'b0;
    for (int cyc = 0; cyc < 5000; cyc++) begin
      if (done) begin
        ok = 1'b1;
        break;
      end
      start = poke && (cyc == 4 || cyc == 40);
      @(negedge clk);
    end
    if (!ok) begin
      n_checks++;
      n_errors++;
      $display("FAIL %s_timeout: got no done, expected done within 5000 cycles", name);
      resetn = 1'b0;
      @(negedge clk);
      resetn = 1'b1;
      return;
    end
    chk({name, "_result_at_done"}, result, exp_res);
    start = poke;
    @(negedge clk);
    start = 1'b0;
    repeat (20) @(negedge clk);
    chk({name, "_result_held"}, result, exp_res);
    chk({name, "_mm_count"}, n_mm - base_mm, exp_mm);
    chk({name, "_done_count"}, n_done - base_done, 1);
    chk({name, "_busy_after"}, busy, 0);
  endtask

  initial begin
    int seen;
    vt[0] = '{16'd3,     16'd5,      16'd7,      16'd5,     7};
    vt[1] = '{16'd10,    16'd0,      16'd13,     16'd1,     2};
    vt[2] = '{16'd10,    16'd1,      16'd13,     16'd10,    4};
    vt[3] = '{16'd2,     16'hFFFF,   16'hFFF1,   16'd32768, 34};
    vt[4] = '{16'd7,     16'd13,     16'd11,     16'd2,     9};
    vt[5] = '{16'd0,     16'd3,      16'd7,      16'd0,     6};
    vt[6] = '{16'd6,     16'd2,      16'd7,      16'd1,     5};
    vt[7] = '{16'd256,   16'd2,      16'hFFF1,   16'd15,    5};
    vt[8] = '{16'd65520, 16'd3,      16'hFFF1,   16'd65520, 6};
    vt[9] = '{16'd5,     16'h8000,   16'hFFF1,   W'(gpow(5, 32768, 65521)), 19};

    resetn = 1'b0;
    repeat (3) @(negedge clk);
    check_zero("reset");
    resetn = 1'b1;

    for (int i = 0; i < 10; i++)
      run(vt[i].x, vt[i].e, vt[i].m, vt[i].res, vt[i].mm, 1'b0, $sformatf("vec%0d", i));

    // Restart attempts while busy and in the DONE cycle must be ignored.
    run(16'd3, 16'd5, 16'd7, 16'd5, 7, 1'b1, "poke");

    // Abort during the first squaring (second multiplier request of the run).
    @(negedge clk);
    setup(16'd3, 16'd5, 16'd7);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    seen = 0;
    for (int cyc = 0; cyc < 5000 && seen < 2; cyc++) begin
      @(negedge clk);
      if (mm_start) seen++;
    end
    chk("abort_reach_w_sq", seen, 2);
    resetn = 1'b0;
    @(negedge clk);
    resetn = 1'b1;
    check_zero("abort");
    repeat (50) @(negedge clk);
    chk("abort_stays_idle_busy", busy, 0);
    run(16'd3, 16'd5, 16'd7, 16'd5, 7, 1'b0, "after_abort");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
